// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared number type and width helpers for the pipeline stages
package pipeline_pkg;

    localparam int NUM_WIDTH = 5;

    typedef logic [NUM_WIDTH-1:0] num_t;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_stage_if.sv
// rtl/fifo_stage_if.sv - valid/ready/num handshake bundle for fifo_stage
interface fifo_stage_if
    import pipeline_pkg::*;
#(
    parameter int WIDTH = NUM_WIDTH,
    parameter int DEPTH = 4
) ();

    localparam int CNT_W = count_width(DEPTH);

    logic             prev_valid;
    logic             this_ready;
    logic             this_valid;
    logic             next_ready;
    logic [WIDTH-1:0] input_num;
    logic [WIDTH-1:0] output_num;
    logic [CNT_W-1:0] count;

    // slave is the stage itself; master is whatever surrounds it
    modport slave (
        input  prev_valid, next_ready, input_num,
        output this_ready, this_valid, output_num, count
    );

    modport master (
        output prev_valid, next_ready, input_num,
        input  this_ready, this_valid, output_num, count
    );

endinterface

// File: rtl/fifo_stage.sv
// rtl/fifo_stage.sv - elastic FIFO buffering stage, DEPTH entries, registered controls
module fifo_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH = NUM_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    fifo_stage_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_stage: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    // Ready depends only on reset and stored occupancy, never on next_ready.
    assign bus.this_ready = !reset && (count_q != FULL_CNT);
    assign bus.this_valid = (count_q != '0);
    assign bus.output_num = bus.this_valid ? mem[rd_ptr] : '0;
    assign bus.count      = count_q;

    assign push = bus.prev_valid && bus.this_ready;
    assign pop  = bus.this_valid && bus.next_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.input_num;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FORMAL
    always_comb begin
        if (!reset) begin
            assert (count_q <= FULL_CNT);
            assert (bus.this_valid == (count_q != '0));
            assert (!bus.this_ready || (count_q < FULL_CNT));
            assert (count_q[PTR_W-1:0] == PTR_W'(wr_ptr - rd_ptr));
            if (wr_ptr == rd_ptr) begin
                assert ((count_q == '0) || (count_q == FULL_CNT));
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        (bus.this_valid && !bus.next_ready) |=> (bus.this_valid && $stable(bus.output_num)));
`endif

endmodule

// File: tb/tb_fifo_stage.sv
// tb/tb_fifo_stage.sv - table-driven directed bench for fifo_stage
module tb_fifo_stage;

    localparam int WIDTH = 5;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    fifo_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       pv;
        logic       nr;
        logic [4:0] num;
        logic       e_rdy;
        logic       e_vld;
        logic [4:0] e_out;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    task automatic add(input logic rst, input logic pv, input logic nr, input int num,
                       input logic e_rdy, input logic e_vld, input int e_out, input int e_cnt);
        vec_t v;
        v.rst = rst; v.pv = pv; v.nr = nr; v.num = 5'(num);
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_out = 5'(e_out); v.e_cnt = 3'(e_cnt);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_outputs(input string tag, input int e_rdy, input int e_vld,
                                 input int e_out, input int e_cnt);
        chk({tag, " this_ready"}, int'(bus.this_ready), e_rdy);
        chk({tag, " this_valid"}, int'(bus.this_valid), e_vld);
        chk({tag, " output_num"}, int'(bus.output_num), e_out);
        chk({tag, " count"},      int'(bus.count),      e_cnt);
    endtask

    // Expected values describe the state seen just before the following rising edge.
    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.prev_valid = 1'b0;
        bus.next_ready = 1'b0;
        bus.input_num  = '0;

        //  rst pv nr num   rdy vld out cnt
        add(1, 1, 0, 3,     0, 0, 0, 0);
        add(1, 1, 1, 3,     0, 0, 0, 0);
        add(0, 0, 1, 0,     1, 0, 0, 0);
        add(0, 1, 1, 7,     1, 0, 0, 0);
        add(0, 0, 1, 0,     1, 1, 7, 1);
        add(0, 0, 0, 0,     1, 0, 0, 0);
        add(0, 1, 0, 1,     1, 0, 0, 0);
        add(0, 1, 0, 2,     1, 1, 1, 1);
        add(0, 1, 0, 3,     1, 1, 1, 2);
        add(0, 1, 0, 4,     1, 1, 1, 3);
        add(0, 1, 0, 5,     0, 1, 1, 4);
        add(0, 1, 0, 5,     0, 1, 1, 4);
        add(0, 1, 1, 5,     0, 1, 1, 4);
        add(0, 1, 1, 5,     1, 1, 2, 3);
        add(0, 1, 1, 6,     1, 1, 3, 3);
        add(0, 1, 1, 7,     1, 1, 4, 3);
        add(0, 0, 1, 0,     1, 1, 5, 3);
        add(0, 0, 1, 0,     1, 1, 6, 2);
        add(0, 0, 1, 0,     1, 1, 7, 1);
        add(0, 0, 0, 0,     1, 0, 0, 0);
        add(0, 1, 0, 9,     1, 0, 0, 0);
        add(0, 1, 0, 10,    1, 1, 9, 1);
        add(0, 1, 1, 11,    1, 1, 9, 2);
        add(0, 0, 1, 0,     1, 1, 10, 2);
        add(0, 0, 1, 0,     1, 1, 11, 1);
        add(0, 0, 0, 0,     1, 0, 0, 0);
        add(0, 1, 0, 12,    1, 0, 0, 0);
        add(0, 1, 0, 13,    1, 1, 12, 1);
        add(0, 1, 0, 14,    1, 1, 12, 2);
        add(0, 0, 0, 0,     1, 1, 12, 3);
        add(1, 1, 1, 15,    0, 0, 0, 0);
        add(0, 1, 1, 20,    1, 0, 0, 0);
        add(0, 0, 1, 0,     1, 1, 20, 1);
        add(0, 0, 0, 0,     1, 0, 0, 0);
        add(0, 1, 0, 31,    1, 0, 0, 0);
        add(0, 0, 1, 0,     1, 1, 31, 1);
        add(0, 0, 0, 0,     1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset          = vecs[i].rst;
            bus.prev_valid = vecs[i].pv;
            bus.next_ready = vecs[i].nr;
            bus.input_num  = vecs[i].num;
            #1;
            check_outputs($sformatf("v%0d", i), int'(vecs[i].e_rdy), int'(vecs[i].e_vld),
                          int'(vecs[i].e_out), int'(vecs[i].e_cnt));
        end

        // Reset pulse between clock edges while holding three entries.
        @(negedge clk);
        bus.next_ready = 1'b0;
        bus.prev_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.input_num = 5'(16 + k);
            @(negedge clk);
        end
        bus.prev_valid = 1'b0;
        #1;
        check_outputs("prefill", 1, 1, 16, 3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("async_rst", 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_outputs("post_rst", 1, 0, 0, 0);

        // Push latency: visible immediately after the accepting edge, bounded wait.
        bus.prev_valid = 1'b1;
        bus.input_num  = 5'd21;
        @(posedge clk);
        #1;
        bus.prev_valid = 1'b0;
        begin
            int waited;
            waited = 0;
            while (!bus.this_valid && waited < 8) begin
                @(posedge clk);
                #1;
                waited++;
            end
            chk("latency_cycles", waited, 0);
            chk("latency_data", int'(bus.output_num), 21);
        end

        // Stall stability with data held over several cycles.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d data", k), int'(bus.output_num), 21);
            chk($sformatf("stall%0d valid", k), int'(bus.this_valid), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got %0d, want %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
